// File: rtl/fp_operand_unpack.sv
// FP add/sub front-end: unpack, classify, magnitude-order two singles and precompute special results.
// 2-cycle latency, 1 op/cycle, stalls on out_ready. FP_DENORM_FLUSH_EN flushes denormal inputs to signed zero.
module fp_operand_unpack #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int SHIFT_SAT = 25,
  localparam int W        = 1 + EXP_W + MAN_W,
  localparam int DIFF_W   = $clog2(SHIFT_SAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      op_a,
  input  logic [W-1:0]      op_b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  sel_exp,
  output logic [DIFF_W-1:0] exp_diff,
  output logic [MAN_W:0]    mant_big,
  output logic [MAN_W:0]    mant_small,
  output logic              sign_res,
  output logic              eop,
  output logic              swap,
  output logic              special,
  output logic [W-1:0]      special_result
);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
    logic             nan;
    logic             inf;
    logic             zero;
`ifndef FP_DENORM_FLUSH_EN
    logic             den;
`endif
  } opnd_t;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic opnd_t unpack(input logic s, input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    opnd_t o;
    o      = '0;
    o.sign = s;
    o.nan  = (e == '1) && (m != '0);
    o.inf  = (e == '1) && (m == '0);
`ifdef FP_DENORM_FLUSH_EN
    o.zero = (e == '0);
    if (!o.zero) begin
      o.exp  = e;
      o.mant = {1'b1, m};
    end
`else
    o.zero = (e == '0) && (m == '0);
    o.den  = (e == '0) && (m != '0);
    // Denormals sit at the minimum normal exponent without the hidden bit.
    if (o.den) begin
      o.exp  = EXP_W'(1);
      o.mant = {1'b0, m};
    end else if (!o.zero) begin
      o.exp  = e;
      o.mant = {1'b1, m};
    end
`endif
    return o;
  endfunction

  // Original encoding of an operand (with effective sign), used when it passes through a zero.
  function automatic logic [W-1:0] raw_bits(input opnd_t o);
`ifdef FP_DENORM_FLUSH_EN
    return {o.sign, o.exp, o.mant[MAN_W-1:0]};
`else
    return {o.sign, (o.den ? {EXP_W{1'b0}} : o.exp), o.mant[MAN_W-1:0]};
`endif
  endfunction

  logic  s1_v;
  logic  s1_rdy;
  logic  s2_rdy;
  opnd_t s1_a;
  opnd_t s1_b;
  opnd_t a_in;
  opnd_t b_in;

  assign s2_rdy   = !out_valid || out_ready;
  assign s1_rdy   = !s1_v || s2_rdy;
  assign in_ready = s1_rdy;

  assign a_in = unpack(op_a[W-1], op_a[W-2 -: EXP_W], op_a[MAN_W-1:0]);
  assign b_in = unpack(op_b[W-1] ^ sub, op_b[W-2 -: EXP_W], op_b[MAN_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
    end else if (s1_rdy) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a <= a_in;
        s1_b <= b_in;
      end
    end
  end

  logic              swap_c;
  logic [EXP_W-1:0]  big_exp;
  logic [EXP_W-1:0]  small_exp;
  logic [MAN_W:0]    big_mant;
  logic [MAN_W:0]    small_mant;
  logic [EXP_W:0]    diff_full;
  logic [DIFF_W-1:0] diff_sat;
  logic              eop_c;
  logic              sign_c;
  logic              special_c;
  logic [W-1:0]      result_c;

  always_comb begin
    swap_c     = {s1_b.exp, s1_b.mant} > {s1_a.exp, s1_a.mant};
    big_exp    = swap_c ? s1_b.exp  : s1_a.exp;
    small_exp  = swap_c ? s1_a.exp  : s1_b.exp;
    big_mant   = swap_c ? s1_b.mant : s1_a.mant;
    small_mant = swap_c ? s1_a.mant : s1_b.mant;
    // One extra bit so the difference never wraps before saturation.
    diff_full  = {1'b0, big_exp} - {1'b0, small_exp};
    if (diff_full > (EXP_W+1)'(SHIFT_SAT)) diff_sat = DIFF_W'(SHIFT_SAT);
    else                                   diff_sat = diff_full[DIFF_W-1:0];
    eop_c      = s1_a.sign ^ s1_b.sign;
    sign_c     = swap_c ? s1_b.sign : s1_a.sign;
  end

  always_comb begin
    special_c = 1'b1;
    result_c  = '0;
    if (s1_a.nan || s1_b.nan) begin
      result_c = QNAN;
    end else if (s1_a.inf && s1_b.inf && eop_c) begin
      result_c = QNAN;
    end else if (s1_a.inf) begin
      result_c = {s1_a.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_b.inf) begin
      result_c = {s1_b.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_a.zero && s1_b.zero) begin
      result_c = {s1_a.sign & s1_b.sign, {(W-1){1'b0}}};
    end else if (s1_a.zero) begin
      result_c = raw_bits(s1_b);
    end else if (s1_b.zero) begin
      result_c = raw_bits(s1_a);
    end else begin
      special_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      sel_exp        <= '0;
      exp_diff       <= '0;
      mant_big       <= '0;
      mant_small     <= '0;
      sign_res       <= 1'b0;
      eop            <= 1'b0;
      swap           <= 1'b0;
      special        <= 1'b0;
      special_result <= '0;
    end else if (s2_rdy) begin
      out_valid <= s1_v;
      if (s1_v) begin
        sel_exp        <= big_exp;
        exp_diff       <= diff_sat;
        mant_big       <= big_mant;
        mant_small     <= small_mant;
        sign_res       <= sign_c;
        eop            <= eop_c;
        swap           <= swap_c;
        special        <= special_c;
        special_result <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Randomized and directed bench for fp_operand_unpack against a value-level reference model.
module tb_fp_operand_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  sel_exp;
  logic [4:0]  exp_diff;
  logic [23:0] mant_big;
  logic [23:0] mant_small;
  logic        sign_res;
  logic        eop;
  logic        swap;
  logic        special;
  logic [31:0] special_result;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  fp_operand_unpack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sel_exp(sel_exp), .exp_diff(exp_diff), .mant_big(mant_big), .mant_small(mant_small),
    .sign_res(sign_res), .eop(eop), .swap(swap), .special(special),
    .special_result(special_result)
  );

  always #5 clk = ~clk;

  wire [127:0] dut_vec = {31'd0, sel_exp, exp_diff, mant_big, mant_small,
                          sign_res, eop, swap, special, special_result};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Operands are ranked by real magnitude; fields follow the IEEE-754 add/sub rules.
  function automatic logic [127:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] op [2];
    bit          sg [2];
    bit          nan [2];
    bit          inf [2];
    bit          zero [2];
    int          ue [2];
    int          um [2];
    longint      mag [2];
    int          bi, si, diff;
    bit          spec;
    logic [31:0] res;
    op[0] = a;
    op[1] = b;
    for (int i = 0; i < 2; i++) begin
      int e, m;
      e       = int'(op[i][30:23]);
      m       = int'(op[i][22:0]);
      sg[i]   = op[i][31];
      nan[i]  = (e == 255) && (m != 0);
      inf[i]  = (e == 255) && (m == 0);
`ifdef FP_DENORM_FLUSH_EN
      zero[i] = (e == 0);
`else
      zero[i] = (e == 0) && (m == 0);
`endif
      if (zero[i])    begin ue[i] = 0; um[i] = 0; end
      else if (e == 0) begin ue[i] = 1; um[i] = m; end
      else            begin ue[i] = e; um[i] = m + (1 << 23); end
      mag[i] = longint'(ue[i]) * 64'd16777216 + longint'(um[i]);
    end
    sg[1] = sg[1] ^ s;
    bi    = (mag[1] > mag[0]) ? 1 : 0;
    si    = 1 - bi;
    diff  = ue[bi] - ue[si];
    if (diff > 25) diff = 25;
    spec = 1'b1;
    res  = 32'd0;
    if (nan[0] || nan[1])                        res = 32'h7FC00000;
    else if (inf[0] && inf[1] && (sg[0] != sg[1])) res = 32'h7FC00000;
    else if (inf[0])                             res = {sg[0], 8'hFF, 23'd0};
    else if (inf[1])                             res = {sg[1], 8'hFF, 23'd0};
    else if (zero[0] && zero[1])                 res = {sg[0] & sg[1], 31'd0};
    else if (zero[0])                            res = {sg[1], op[1][30:0]};
    else if (zero[1])                            res = {sg[0], op[0][30:0]};
    else                                         spec = 1'b0;
    return {31'd0, 8'(ue[bi]), 5'(diff), 24'(um[bi]), 24'(um[si]),
            sg[bi], sg[0] ^ sg[1], 1'(bi), spec, res};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:0] = 31'd0;
      1: r[30:0] = {8'hFF, 23'd0};
      2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      3: begin r[30:23] = 8'h00; r[0] = 1'b1; end
      4: r[30:23] = 8'd127 + 8'($urandom_range(0, 3));
      default: ;
    endcase
    return r;
  endfunction

  // Scoreboard: every accepted op is queued; every presented output is compared, including during stalls.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {127'd0, out_valid}, 128'd0);
        end else begin
          check("out_fields", dut_vec, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic acc;
    int   n;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", {127'd0, acc}, 128'd1);
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, {127'd0, out_valid}, 128'd1);
  endtask

  logic [31:0] ops4 [3];

  initial begin
    int k, seen, n;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; sub = 1'b0;
    tick(); tick();
    check("rst_outputs", dut_vec, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    rst = 1'b0;
    tick();

    // 1.0 + 2.0 with latency check
    op_a = 32'h3F800000; op_b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_lat1_valid", {127'd0, out_valid}, 128'd0);
    tick();
    check("t1_lat2_valid", {127'd0, out_valid}, 128'd1);
    check("t1_sel_exp", 128'(sel_exp), 128'h80);
    check("t1_exp_diff", 128'(exp_diff), 128'd1);
    check("t1_mant_big", 128'(mant_big), 128'h800000);
    check("t1_mant_small", 128'(mant_small), 128'h800000);
    check("t1_swap", 128'(swap), 128'd1);
    check("t1_eop", 128'(eop), 128'd0);
    check("t1_special", 128'(special), 128'd0);
    tick();

    // +inf + -inf
    send(32'h7F800000, 32'hFF800000, 1'b0);
    wait_out("t2_valid");
    check("t2_special", 128'(special), 128'd1);
    check("t2_result", 128'(special_result), 128'h7FC00000);
    tick();

    // 1.0 - 1.0
    send(32'h3F800000, 32'h3F800000, 1'b1);
    wait_out("t3_valid");
    check("t3_eop", 128'(eop), 128'd1);
    check("t3_exp_diff", 128'(exp_diff), 128'd0);
    check("t3_swap", 128'(swap), 128'd0);
    check("t3_sign_res", 128'(sign_res), 128'd0);
    check("t3_special", 128'(special), 128'd0);
    tick();

    // smallest denormal + 1.0
    send(32'h00000001, 32'h3F800000, 1'b0);
    wait_out("t5_valid");
`ifdef FP_DENORM_FLUSH_EN
    check("t5_special", 128'(special), 128'd1);
    check("t5_result", 128'(special_result), 128'h3F800000);
`else
    check("t5_mant_small", 128'(mant_small), 128'h000001);
    check("t5_exp_diff", 128'(exp_diff), 128'd25);
`endif
    tick();

    // back-pressure: three ops against a stalled output
    ops4[0] = 32'h40400000; ops4[1] = 32'hC0A00000; ops4[2] = 32'h3E800000;
    out_ready = 1'b0; k = 0; sub = 1'b0;
    op_a = ops4[0]; op_b = 32'h3F000000; in_valid = 1'b1;
    repeat (4) begin
      acc = in_ready;
      tick();
      if (acc) begin
        k++;
        if (k < 3) op_a = ops4[k];
      end
    end
    check("t4_accepted", 128'(k), 128'd2);
    check("t4_in_ready", {127'd0, in_ready}, 128'd0);
    check("t4_hold_op1", dut_vec, model(ops4[0], 32'h3F000000, 1'b0));
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_op2_valid", {127'd0, out_valid}, 128'd1);
    check("t4_op2", dut_vec, model(ops4[1], 32'h3F000000, 1'b0));
    tick();
    check("t4_op3_valid", {127'd0, out_valid}, 128'd1);
    check("t4_op3", dut_vec, model(ops4[2], 32'h3F000000, 1'b0));
    tick();
    check("t4_empty", {127'd0, out_valid}, 128'd0);

    // reset with two ops in flight
    out_ready = 1'b0;
    send(32'h41200000, 32'h40000000, 1'b0);
    send(32'h42C80000, 32'h3F800000, 1'b1);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("t6_out_valid", {127'd0, out_valid}, 128'd0);
    check("t6_in_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      if (out_valid) seen++;
    end
    check("t6_no_ghost", 128'(seen), 128'd0);

    // randomized traffic with random stalls
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op_a      = gen_op();
      if ($urandom_range(0, 4) == 0) begin
        op_b     = op_a;
        op_b[31] = 1'($urandom_range(0, 1));
      end else begin
        op_b = gen_op();
      end
      sub = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
